// File: rtl/control_unit_fsm_hs.sv
// control_unit_fsm_hs: SigmaCore multicycle control FSM with a req/ready
// memory port, stall timeout, sticky fault and retired-instruction count.
// Ports: clk, reset_n (async, active-low); opcode/funct3/funct7 from IR;
//   alu_zero_flag, mem_ready in; mem_req/mem_we memory port; datapath
//   strobes, pc_source, wb_sel, alu_src_a/b, imm_src, alu_op_type out;
//   retire pulse, retire_count, fault, fault_cause out.
// Build option: define SIGMA_JUMP_EN to decode JAL/JALR.

package sigma_pkg;
  localparam logic [2:0] IMM_TYPE_I    = 3'b000;
  localparam logic [2:0] IMM_TYPE_S    = 3'b001;
  localparam logic [2:0] IMM_TYPE_B    = 3'b010;
  localparam logic [2:0] IMM_TYPE_U    = 3'b011;
  localparam logic [2:0] IMM_TYPE_SLTI = 3'b100;
  localparam logic [2:0] IMM_TYPE_J    = 3'b101;

  localparam logic [1:0] ALU_OP_TYPE_LSU    = 2'b00;
  localparam logic [1:0] ALU_OP_TYPE_BRANCH = 2'b01;
  localparam logic [1:0] ALU_OP_TYPE_R_I    = 2'b10;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [1:0] FC_NONE    = 2'b00;
  localparam logic [1:0] FC_ILLEGAL = 2'b01;
  localparam logic [1:0] FC_TIMEOUT = 2'b10;
endpackage

module control_unit_fsm_hs
  import sigma_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TIMEOUT_W      = 8,
  parameter int RETIRE_W       = 32
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [6:0]          opcode,
  input  logic [2:0]          funct3,
  input  logic [6:0]          funct7,
  input  logic                alu_zero_flag,
  input  logic                mem_ready,
  output logic                mem_req,
  output logic                mem_we,
  output logic                pc_write,
  output logic                ir_write,
  output logic                reg_write,
  output logic                reg_a_write,
  output logic                reg_b_write,
  output logic                alu_out_write,
  output logic [1:0]          pc_source,
  output logic [1:0]          wb_sel,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [2:0]          imm_src,
  output logic [1:0]          alu_op_type,
  output logic                retire,
  output logic [RETIRE_W-1:0] retire_count,
  output logic                fault,
  output logic [1:0]          fault_cause
);

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEM_ADDR,
    S_MEM_RD,
    S_MEM_WR,
    S_WB_MEM,
    S_EXEC_R,
    S_EXEC_I,
    S_WB_ALU,
    S_BRANCH,
    S_FAULT
`ifdef SIGMA_JUMP_EN
    ,
    S_JALR_ADDR,
    S_JUMP
`endif
  } state_t;

  localparam logic [TIMEOUT_W-1:0] TO_LAST =
    TIMEOUT_W'(TIMEOUT_CYCLES - 1);

  state_t               state_q;
  state_t               state_d;
  logic [TIMEOUT_W-1:0] stall_q;
  logic [TIMEOUT_W-1:0] stall_d;
  logic [1:0]           cause_q;
  logic [1:0]           cause_d;

  logic is_lui;
  logic is_opimm;
  logic is_op;
  logic is_mem;
  logic is_store;
  logic is_br;
  logic is_jal;
  logic is_jalr;
  logic req_st;
  logic timeout_hit;

  // funct7 is carried for future ALU decode; no control path uses it yet.
  logic unused_funct7;
  assign unused_funct7 = ^funct7;

  assign is_lui   = opcode == OPC_LUI;
  assign is_opimm = opcode == OPC_OP_IMM;
  assign is_op    = opcode == OPC_OP;
  assign is_store = opcode == OPC_STORE;
  assign is_mem   = (opcode == OPC_LOAD) || is_store;
  assign is_br    = (opcode == OPC_BRANCH) &&
                    (funct3 == 3'b000 || funct3 == 3'b001);
`ifdef SIGMA_JUMP_EN
  assign is_jal   = opcode == OPC_JAL;
  assign is_jalr  = opcode == OPC_JALR;
`else
  assign is_jal   = 1'b0;
  assign is_jalr  = 1'b0;
`endif

  assign req_st = (state_q == S_FETCH) ||
                  (state_q == S_MEM_RD) ||
                  (state_q == S_MEM_WR);

  // Fires in the last allowed stall cycle; ready in that cycle wins.
  assign timeout_hit = req_st && !mem_ready &&
                       (stall_q == TO_LAST);

  assign fault       = state_q == S_FAULT;
  assign fault_cause = cause_q;

  always_comb begin
    state_d       = state_q;
    cause_d       = cause_q;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    pc_write      = 1'b0;
    ir_write      = 1'b0;
    reg_write     = 1'b0;
    reg_a_write   = 1'b0;
    reg_b_write   = 1'b0;
    alu_out_write = 1'b0;
    pc_source     = 2'b00;
    wb_sel        = 2'b00;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    imm_src       = IMM_TYPE_I;
    alu_op_type   = ALU_OP_TYPE_LSU;
    retire        = 1'b0;

    unique case (state_q)
      S_FETCH: begin
        mem_req   = 1'b1;
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        if (mem_ready) begin
          state_d = S_DECODE;
        end else if (timeout_hit) begin
          state_d = S_FAULT;
          cause_d = FC_TIMEOUT;
        end
      end
      S_DECODE: begin
        reg_a_write   = 1'b1;
        reg_b_write   = 1'b1;
        alu_out_write = 1'b1;
        alu_src_a     = 1'b1;
        alu_src_b     = 2'b01;
        imm_src       = is_jal ? IMM_TYPE_J
                               : IMM_TYPE_B;
        unique case (1'b1)
          is_lui:   state_d = S_WB_ALU;
          is_opimm: state_d = S_EXEC_I;
          is_op:    state_d = S_EXEC_R;
          is_mem:   state_d = S_MEM_ADDR;
          is_br:    state_d = S_BRANCH;
`ifdef SIGMA_JUMP_EN
          is_jal:   state_d = S_JUMP;
          is_jalr:  state_d = S_JALR_ADDR;
`endif
          default: begin
            state_d = S_FAULT;
            cause_d = FC_ILLEGAL;
          end
        endcase
      end
      S_MEM_ADDR: begin
        alu_src_b     = 2'b01;
        imm_src       = is_store ? IMM_TYPE_S
                                 : IMM_TYPE_I;
        alu_out_write = 1'b1;
        state_d       = is_store ? S_MEM_WR
                                 : S_MEM_RD;
      end
      S_MEM_RD: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          state_d = S_WB_MEM;
        end else if (timeout_hit) begin
          state_d = S_FAULT;
          cause_d = FC_TIMEOUT;
        end
      end
      S_MEM_WR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        retire  = mem_ready;
        if (mem_ready) begin
          state_d = S_FETCH;
        end else if (timeout_hit) begin
          state_d = S_FAULT;
          cause_d = FC_TIMEOUT;
        end
      end
      S_WB_MEM: begin
        reg_write = 1'b1;
        wb_sel    = 2'b01;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_EXEC_R: begin
        alu_op_type   = ALU_OP_TYPE_R_I;
        alu_out_write = 1'b1;
        state_d       = S_WB_ALU;
      end
      S_EXEC_I: begin
        alu_src_b     = 2'b01;
        imm_src       = (funct3 == 3'b010)
                        ? IMM_TYPE_SLTI
                        : IMM_TYPE_I;
        alu_op_type   = ALU_OP_TYPE_R_I;
        alu_out_write = 1'b1;
        state_d       = S_WB_ALU;
      end
      S_WB_ALU: begin
        reg_write = 1'b1;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_BRANCH: begin
        alu_op_type = ALU_OP_TYPE_BRANCH;
        imm_src     = IMM_TYPE_B;
        pc_source   = 2'b01;
        retire      = 1'b1;
        // funct3[0] separates BNE (001) from BEQ (000).
        pc_write    = funct3[0] ? !alu_zero_flag
                                : alu_zero_flag;
        state_d     = S_FETCH;
      end
`ifdef SIGMA_JUMP_EN
      S_JALR_ADDR: begin
        alu_src_b     = 2'b01;
        alu_out_write = 1'b1;
        state_d       = S_JUMP;
      end
      S_JUMP: begin
        reg_write = 1'b1;
        wb_sel    = 2'b10;
        pc_write  = 1'b1;
        pc_source = 2'b10;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
`endif
      S_FAULT: begin
        state_d = S_FAULT;
      end
      default: begin
        state_d = S_FAULT;
        cause_d = FC_ILLEGAL;
      end
    endcase

    // Reset must drop the bus request at once, not at the next edge.
    if (!reset_n) begin
      mem_req  = 1'b0;
      mem_we   = 1'b0;
      ir_write = 1'b0;
      pc_write = 1'b0;
      retire   = 1'b0;
    end
  end

  always_comb begin
    stall_d = stall_q + 1'b1;
    if (state_d != state_q || !req_st || mem_ready) begin
      stall_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_FETCH;
      stall_q      <= '0;
      cause_q      <= FC_NONE;
      retire_count <= '0;
    end else begin
      state_q <= state_d;
      stall_q <= stall_d;
      cause_q <= cause_d;
      if (retire) begin
        retire_count <= retire_count + RETIRE_W'(1);
      end
    end
  end

endmodule

// File: doc/control_unit_fsm_hs.md
# control_unit_fsm_hs

Multicycle control FSM for the SigmaCore datapath, generalised for variable-latency memory. Adds a req/ready memory handshake with a parametrised timeout, BNE alongside BEQ, optional JAL/JALR, a sticky fault state and a retired-instruction counter. Drives the same datapath strobes as the current control unit, and also drives the new memory port.

## Interface
- TIMEOUT_CYCLES, 255: stall cycles allowed while mem_req waits for mem_ready. Range 1..2^TIMEOUT_W-1.
- TIMEOUT_W, 8: width of the stall counter.
- RETIRE_W, 32: width of retire_count.
- clk  in  1  system clock
- reset_n  in  1  reset is asynchronous and active-low
- opcode / funct3 / funct7  in  7/3/7  fields from the IR
- alu_zero_flag  in  1  ALU result == 0
- mem_ready  in  1  memory completes the current request this cycle
- mem_req  out  1  memory request; held until mem_ready
- mem_we  out  1  request is a write (valid with mem_req)
- pc_write, ir_write, reg_write, reg_a_write, reg_b_write, alu_out_write  out  1 each  datapath latch strobes
- pc_source  out  2  00 PC+4 (ALU), 01 branch target, 10 ALUOut (jump target)
- wb_sel  out  2  00 ALU/ALUOut, 01 memory data, 10 PC (link)
- alu_src_a  out  1  0 register A, 1 PC
- alu_src_b  out  2  00 register B, 01 immediate, 10 constant 4
- imm_src  out  3  sigma_pkg IMM_TYPE_* encoding; IMM_TYPE_J = 3'b101 is added to sigma_pkg
- alu_op_type  out  2  sigma_pkg ALU_OP_TYPE_*
- retire  out  1  one-cycle pulse in the final cycle of each instruction
- retire_count  out  RETIRE_W  retired instructions, wraps modulo 2^RETIRE_W
- fault  out  1  sticky, set on illegal instruction or timeout
- fault_cause  out  2  00 none, 01 illegal, 10 timeout

## Operation
- States: FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WR, WB_MEM, EXEC_R, EXEC_I, WB_ALU, BRANCH, JALR_ADDR, JUMP, FAULT.
- FETCH:
  - mem_req=1, alu_src_a=1, alu_src_b=10, alu_op_type=LSU.
  - ir_write and pc_write are asserted only in the cycle mem_ready=1; the FSM then moves to DECODE. Otherwise it stays in FETCH.
- DECODE:
  - reg_a_write=reg_b_write=alu_out_write=1.
  - alu_src_a=1, alu_src_b=01, imm_src=B. ALUOut therefore holds PC+imm, with the J immediate used when the opcode is JAL.
  - Dispatch by opcode:
    - LUI (0110111) -> WB_ALU
    - OP-IMM (0010011) -> EXEC_I
    - OP (0110011) -> EXEC_R
    - LOAD (0000011) / STORE (0100011) -> MEM_ADDR
    - BRANCH (1100011) with funct3 000/001 -> BRANCH
    - JAL (1101111) -> JUMP
    - JALR (1100111) -> JALR_ADDR
    - anything else -> FAULT (cause 01). BRANCH with any other funct3 also faults with cause 01.
- MEM_ADDR: computes A + imm (imm_src S or I), alu_out_write=1. Goes to MEM_WR for stores, MEM_RD for loads.
- MEM_RD: mem_req=1, mem_we=0. Waits for mem_ready, then goes to WB_MEM.
- MEM_WR: mem_req=1, mem_we=1. Waits for mem_ready, then goes to FETCH with retire=1.
- WB_MEM: reg_write=1, wb_sel=01, retire=1.
- EXEC_R / EXEC_I:
  - Operand B is register B (EXEC_R) or the immediate (EXEC_I).
  - EXEC_I uses imm_src=SLTI when funct3=010, otherwise I.
  - alu_op_type=R_I, alu_out_write=1. Next state is WB_ALU.
- WB_ALU: reg_write=1, wb_sel=00, retire=1.
- BRANCH:
  - ALU compares A and B; pc_source=01, retire=1.
  - pc_write = alu_zero_flag for BEQ, !alu_zero_flag for BNE.
- JALR_ADDR: computes A + I-imm, alu_out_write=1. Next state is JUMP.
- JUMP: reg_write=1, wb_sel=10, pc_write=1, pc_source=10, retire=1.
- FAULT: all strobes and mem_req are 0. The FSM stays here until reset.
- Stall counter:
  - Clears on entering any mem_req state and whenever mem_ready=1.
  - Increments each cycle mem_req=1 && !mem_ready.
  - Reaching TIMEOUT_CYCLES moves the FSM to FAULT (cause 10) on the next edge. mem_req drops once in FAULT.
- A simultaneous mem_ready and timeout hit completes the transfer; ready wins.

## Timing
- Reset values: state=FETCH, all strobes 0 except the FETCH Moore outputs (mem_req=1 after reset release), retire_count=0, fault=0, fault_cause=00, stall counter 0.
- Outputs are Moore decoded from state, except these combinational terms:
  - ir_write/pc_write in FETCH, gated by mem_ready
  - pc_write in BRANCH
  - retire in MEM_WR
- Zero-wait latency (clocks per instruction): LUI 3, R/I 4, load 5, store 4, branch 3, JAL 3, JALR 4. Each mem_ready wait cycle adds 1.
- retire_count increments on the edge that ends the retiring cycle.
- Reset asserted mid-transfer drops mem_req asynchronously. A transfer aborted this way leaves no state behind.

## Configuration
- SIGMA_JUMP_EN defined: JAL/JALR are decoded, and the JALR_ADDR and JUMP states exist.
- SIGMA_JUMP_EN undefined: opcodes 1101111/1100111 go to FAULT with cause 01, and those states are not generated.

## Test plan
- ADD with mem_ready tied 1 -> FETCH, DECODE, EXEC_R, WB_ALU; reg_write in cycle 4; retire_count 0->1.
- LW with mem_ready delayed 3 cycles in both FETCH and MEM_RD -> ir_write only on the ready cycle; total 11 cycles; wb_sel=01 during reg_write.
- BNE with alu_zero_flag=0 -> pc_write=1, pc_source=01. BEQ with alu_zero_flag=0 -> pc_write=0. Both retire.
- mem_ready held 0 with TIMEOUT_CYCLES=4 -> FAULT after 4 stall cycles; fault=1, cause=10, mem_req=0; reset_n pulse returns to FETCH with fault cleared.
- Opcode 0001111, plus JAL with SIGMA_JUMP_EN undefined -> FAULT, cause 01. JAL with the macro defined -> reg_write=1, wb_sel=10, pc_source=10, 3 cycles.
- reset_n asserted during the MEM_WR wait -> mem_req=0 immediately; retire_count=0; FETCH after release.
